ctrl_pipe_unit: RTL and testbench
=================================

# ctrl_pipe_unit

Pipelined main control unit for the MIPS-lite core, sitting between the ID and EX stages. It decodes opcode and funct into the 12-bit control word and registers it, with the resolved register addresses, into the ID/EX control register. It also generates the ID stall for load-use hazards and for a multi-cycle multiply, and handles external stall, flush and illegal-opcode cases.

## Interface
- `ALU_OP_W`, 3, ALU operation field width; the control word is 9 + `ALU_OP_W` bits.
- `REG_W`, 5, register address width.
- `MUL_LAT`, 4, number of cycles a MULT occupies EX. Must be at least 1.
- `CNT_W`, 16, width of the bubble statistics counter.

Ports (clock and reset first):
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: ID holds a valid instruction.
- `op` in 6: opcode.
- `funct` in 6: R-type funct field.
- `rs`, `rt`, `rd` in `REG_W` each: source and destination register fields.
- `stall_ext` in 1: downstream stall; freezes this unit.
- `flush` in 1: discard the ID instruction.
- `id_stall` out 1: hold PC and IF/ID.
- `ex_valid` out 1: EX holds a real instruction.
- `ex_ctrl` out 9+`ALU_OP_W`: {RegDst, Branch, Jmp, WbSel, MemRead, MemWrite, AluSrc, RegWrite, ExtOp, AluOp}.
- `ex_rs`, `ex_rt` out `REG_W`: source register addresses.
- `ex_wa` out `REG_W`: write address, `rd` if RegDst is set, else `rt`.
- `ex_busy` out 1: a multiply occupies EX.
- `illegal` out 1: one-cycle pulse when an undecodable opcode is accepted.
- `bubble_cnt` out `CNT_W`: number of bubbles inserted for hazards; saturates at all-ones.

## Operation
- Decode table, control word before AluOp, then AluOp:
  - R_TYPE `000000`: `100000010`, `011`
  - ORI `001101`: `000000110`, `010`
  - LW `100011`: `000110111`, `000`
  - SW `101011`: `000001101`, `000`
  - BEQ `000100`: `010000000`, `001`
  - JAL `000011`: `001000000`, `000`
  - XORI `001110`: `000000110`, `100`
  - Any other opcode: all zeros; asserts `illegal`; loads a bubble into EX.
- The instruction uses `rt` as a source for R_TYPE, SW and BEQ only.
- Load-use hazard when all of the following hold: `ex_valid`, `ex_ctrl` MemRead, `ex_wa` is not 0, and `ex_wa` equals `rs`, or equals `rt` when the instruction uses `rt`, while `in_valid`.
  - Response: `id_stall`=1, EX is loaded with a bubble, `bubble_cnt` increments.
- MULT is R_TYPE with funct `011000`.
  - On load into EX: state becomes BUSY, `cnt` = `MUL_LAT`-1.
  - In BUSY with `cnt` not 0: EX holds, `id_stall`=1, `cnt` decrements.
  - In BUSY with `cnt`=0: behaves as IDLE and accepts the next instruction. State returns to IDLE unless that instruction is another MULT.
- States: IDLE and BUSY.
- Per-cycle priority, highest first:
  1. `stall_ext`: all registers hold, `id_stall`=1, `cnt` frozen, `flush` ignored; the source holds `flush` until it is accepted.
  2. `flush`: the ID instruction is treated as `in_valid`=0. EX receives a bubble unless BUSY with `cnt` not 0, in which case EX holds.
  3. BUSY hold.
  4. Load-use bubble.
  5. Normal load.
- A bubble is `ex_valid`=0 with `ex_ctrl`, `ex_wa`, `ex_rs` and `ex_rt` all 0.
- `illegal` is not asserted for flushed, stalled or invalid cycles.

## Timing
- All outputs are registered, except `id_stall`, which is combinational from the current inputs and state.
- Decode latency: 1 cycle. An instruction present at edge N appears on the `ex_*` outputs after edge N.
- A load-use hazard costs exactly 1 bubble cycle. A MULT costs `MUL_LAT`-1 stall cycles. `MUL_LAT`=1 produces no stall.
- `ex_busy` stays high for exactly `MUL_LAT` consecutive non-stalled cycles per MULT, and is extended by `stall_ext` cycles.
- `illegal` pulses in the cycle after acceptance, aligned with the bubble.
- Reset values (asynchronous, applied on `rst_n` low, including mid-multiply):
  - State IDLE, `cnt`=0.
  - `ex_valid`, `ex_ctrl`, `ex_rs`, `ex_rt`, `ex_wa`, `ex_busy`, `illegal`, `bubble_cnt` all 0.
  - `id_stall` is 0 while in reset.

## Structure
- Package `ctrl_pkg`: opcode constants, `FUNCT_MULT`, control word width, the decode encodings, the bubble constant, and the state enum.
- Sub-module `ctrl_decode`: purely combinational decoder. Inputs `op`, `funct`; outputs the control word, `uses_rt`, `is_mult`, `is_illegal`. It is instantiated once.
- The top level contains the hazard compare, the FSM and counter, the EX register and the statistics counter.

## Test plan
- Reset test: assert `rst_n`=0 mid-MULT at `cnt`=2.
  - Required: all outputs read 0 immediately, state IDLE.
  - Required: the first instruction after release decodes normally.
- ORI decode: ORI with `rt`=7, `rd`=3, `in_valid`=1.
  - Required, next cycle: `ex_ctrl`=`000000110010`, `ex_wa`=7, `ex_valid`=1.
  - Repeat for all seven opcodes.
- Load-use: LW with `rt`=5 followed by R_TYPE with `rs`=5.
  - Required: `id_stall`=1 for one cycle, one bubble, then the R-type enters EX, `bubble_cnt`=1.
  - Repeat with `ex_wa`=0: required, no stall.
- Multiply: MULT with `MUL_LAT`=4.
  - Required: `ex_busy` high for 4 cycles, `id_stall` high for 3 cycles, following instruction enters on cycle 5.
  - Required: 2 `stall_ext` cycles inserted mid-multiply extend `ex_busy` to 6 cycles.
- Same-cycle `flush` and `stall_ext`, then `flush` alone.
  - Required: a full hold first, then a bubble with `illegal`=0.
- Illegal opcode: op `111111` with `in_valid`=1.
  - Required: `illegal` pulses for 1 cycle, and EX holds a bubble.
  - Required: `bubble_cnt` saturates at all-ones with `CNT_W`=2 after 5 hazards.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared constants and types for the ID/EX main control unit.
package ctrl_pkg;

  // Control word layout above the AluOp field:
  // {RegDst, Branch, Jmp, WbSel, MemRead, MemWrite, AluSrc, RegWrite, ExtOp}
  localparam int CTRL_HI_W  = 9;
  localparam int ALU_BASE_W = 3;
  // Bit offsets above the AluOp field
  localparam int MEMREAD_OFS = 4;
  localparam int REGDST_OFS  = 8;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_XORI  = 6'b001110;

  localparam logic [5:0] FUNCT_MULT = 6'b011000;

  localparam logic [CTRL_HI_W-1:0] HI_RTYPE = 9'b100000010;
  localparam logic [CTRL_HI_W-1:0] HI_ORI   = 9'b000000110;
  localparam logic [CTRL_HI_W-1:0] HI_LW    = 9'b000110111;
  localparam logic [CTRL_HI_W-1:0] HI_SW    = 9'b000001101;
  localparam logic [CTRL_HI_W-1:0] HI_BEQ   = 9'b010000000;
  localparam logic [CTRL_HI_W-1:0] HI_JAL   = 9'b001000000;
  localparam logic [CTRL_HI_W-1:0] HI_XORI  = 9'b000000110;
  localparam logic [CTRL_HI_W-1:0] HI_BUBBLE = '0;

  localparam logic [ALU_BASE_W-1:0] ALU_RTYPE = 3'b011;
  localparam logic [ALU_BASE_W-1:0] ALU_ORI   = 3'b010;
  localparam logic [ALU_BASE_W-1:0] ALU_ADD   = 3'b000;
  localparam logic [ALU_BASE_W-1:0] ALU_SUB   = 3'b001;
  localparam logic [ALU_BASE_W-1:0] ALU_XORI  = 3'b100;
  localparam logic [ALU_BASE_W-1:0] ALU_BUBBLE = '0;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} ctrl_state_e;

  // What the EX register does this cycle
  typedef enum logic [1:0] {EX_HOLD = 2'd0, EX_BUBBLE = 2'd1, EX_LOAD = 2'd2} ex_act_e;

endpackage

// File: rtl/ctrl_pipe_unit_decode.sv
// Combinational opcode/funct decoder producing the control word.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0]            op,
  input  logic [5:0]            funct,
  output logic [CTRL_HI_W-1:0]  ctrl_hi,
  output logic [ALU_BASE_W-1:0] alu_op,
  output logic                  uses_rt,
  output logic                  is_mult,
  output logic                  is_illegal
);

  // Decode table; anything not listed is illegal and decodes to a bubble
  always_comb begin
    ctrl_hi    = HI_BUBBLE;
    alu_op     = ALU_BUBBLE;
    uses_rt    = 1'b0;
    is_mult    = 1'b0;
    is_illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        ctrl_hi = HI_RTYPE; alu_op = ALU_RTYPE; uses_rt = 1'b1;
        is_mult = (funct == FUNCT_MULT);
      end
      OP_ORI:  begin ctrl_hi = HI_ORI;  alu_op = ALU_ORI;  end
      OP_LW:   begin ctrl_hi = HI_LW;   alu_op = ALU_ADD;  end
      OP_SW:   begin ctrl_hi = HI_SW;   alu_op = ALU_ADD;  uses_rt = 1'b1; end
      OP_BEQ:  begin ctrl_hi = HI_BEQ;  alu_op = ALU_SUB;  uses_rt = 1'b1; end
      OP_JAL:  begin ctrl_hi = HI_JAL;  alu_op = ALU_ADD;  end
      OP_XORI: begin ctrl_hi = HI_XORI; alu_op = ALU_XORI; end
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// ID/EX main control: decode, load-use and multiply stalls, EX register.
// Handshake: id_stall=1 means ID must hold its instruction (PC and IF/ID
// frozen); when id_stall=0 and in_valid=1 the instruction is consumed at
// the next rising edge. stall_ext freezes everything here; flush drops the
// ID instruction for that cycle.
module ctrl_pipe_unit
  import ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 3,
  parameter int REG_W    = 5,
  parameter int MUL_LAT  = 4,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [5:0]            op,
  input  logic [5:0]            funct,
  input  logic [REG_W-1:0]      rs,
  input  logic [REG_W-1:0]      rt,
  input  logic [REG_W-1:0]      rd,
  input  logic                  stall_ext,
  input  logic                  flush,
  output logic                  id_stall,
  output logic                  ex_valid,
  output logic [8+ALU_OP_W:0]   ex_ctrl,
  output logic [REG_W-1:0]      ex_rs,
  output logic [REG_W-1:0]      ex_rt,
  output logic [REG_W-1:0]      ex_wa,
  output logic                  ex_busy,
  output logic                  illegal,
  output logic [CNT_W-1:0]      bubble_cnt,
  output ctrl_state_e           state_dbg
);

  localparam int CW       = 9 + ALU_OP_W;
  localparam int CNT_BITS = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  logic [CTRL_HI_W-1:0]  dec_hi;
  logic [ALU_BASE_W-1:0] dec_alu;
  logic                  dec_uses_rt, dec_mult, dec_illegal;

  ctrl_decode u_decode (
    .op         (op),
    .funct      (funct),
    .ctrl_hi    (dec_hi),
    .alu_op     (dec_alu),
    .uses_rt    (dec_uses_rt),
    .is_mult    (dec_mult),
    .is_illegal (dec_illegal)
  );

  ctrl_state_e         state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  ex_act_e             act;
  logic                ill_d, bump;

  logic [CW-1:0]    ctrl_word;
  logic [REG_W-1:0] wa_next;
  logic             take, busy_hold, load_use;

  assign ctrl_word = {dec_hi, ALU_OP_W'(dec_alu)};
  assign wa_next   = dec_hi[REGDST_OFS] ? rd : rt;
  assign take      = in_valid & ~flush;
  assign busy_hold = (state_q == BUSY) && (cnt_q != '0);

  // Load-use: the load in EX writes a register this instruction reads
  assign load_use = take && ex_valid && ex_ctrl[ALU_OP_W + MEMREAD_OFS] &&
                    (ex_wa != '0) &&
                    ((ex_wa == rs) || (dec_uses_rt && (ex_wa == rt)));

  // Stall is combinational so ID sees it in the same cycle
  assign id_stall  = rst_n & (stall_ext | busy_hold | load_use);
  assign state_dbg = state_q;

  // FSM state and multiply countdown register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and EX action, highest priority first
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act     = EX_HOLD;
    ill_d   = 1'b0;
    bump    = 1'b0;
    if (!stall_ext) begin
      if (busy_hold) begin
        act   = EX_HOLD;
        cnt_d = cnt_q - CNT_BITS'(1);
      end else if (!take) begin
        act     = EX_BUBBLE;
        state_d = IDLE;
      end else if (load_use) begin
        act     = EX_BUBBLE;
        state_d = IDLE;
        bump    = 1'b1;
      end else if (dec_illegal) begin
        act     = EX_BUBBLE;
        state_d = IDLE;
        ill_d   = 1'b1;
      end else begin
        act = EX_LOAD;
        if (dec_mult) begin
          state_d = BUSY;
          cnt_d   = CNT_BITS'(MUL_LAT - 1);
        end else begin
          state_d = IDLE;
        end
      end
    end
  end

  // ID/EX control register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_wa    <= '0;
      ex_busy  <= 1'b0;
    end else if (act == EX_LOAD) begin
      ex_valid <= 1'b1;
      ex_ctrl  <= ctrl_word;
      ex_rs    <= rs;
      ex_rt    <= rt;
      ex_wa    <= wa_next;
      ex_busy  <= dec_mult;
    end else if (act == EX_BUBBLE) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_wa    <= '0;
      ex_busy  <= 1'b0;
    end
  end

  // Illegal pulse and saturating hazard-bubble counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal    <= 1'b0;
      bubble_cnt <= '0;
    end else begin
      illegal <= ill_d;
      if (bump && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Directed bench for ctrl_pipe_unit with an expected-queue scoreboard.
module tb_ctrl_pipe_unit;
  import ctrl_pkg::*;

  localparam int REC_W = 48;

  localparam logic [11:0] C_R    = 12'b100000010_011;
  localparam logic [11:0] C_ORI  = 12'b000000110_010;
  localparam logic [11:0] C_LW   = 12'b000110111_000;
  localparam logic [11:0] C_SW   = 12'b000001101_000;
  localparam logic [11:0] C_BEQ  = 12'b010000000_001;
  localparam logic [11:0] C_JAL  = 12'b001000000_000;
  localparam logic [11:0] C_XORI = 12'b000000110_100;
  localparam logic [5:0]  OP_BAD = 6'b111111;
  localparam logic [5:0]  F_ADD  = 6'b100000;

  logic clk, rst_n;
  logic in_valid, stall_ext, flush;
  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;

  logic id_stall, ex_valid, ex_busy, illegal;
  logic [11:0] ex_ctrl;
  logic [4:0] ex_rs, ex_rt, ex_wa;
  logic [15:0] bubble_cnt;
  ctrl_state_e state_dbg;

  logic id_stall2, ex_valid2, ex_busy2, illegal2;
  logic [11:0] ex_ctrl2;
  logic [4:0] ex_rs2, ex_rt2, ex_wa2;
  logic [1:0] bubble_cnt2;
  ctrl_state_e state_dbg2;

  logic [REC_W-1:0] exp_q[$];
  int n_checks, n_pass, bc_e;

  ctrl_pipe_unit #(.ALU_OP_W(3), .REG_W(5), .MUL_LAT(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op), .funct(funct),
    .rs(rs), .rt(rt), .rd(rd), .stall_ext(stall_ext), .flush(flush),
    .id_stall(id_stall), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wa(ex_wa), .ex_busy(ex_busy),
    .illegal(illegal), .bubble_cnt(bubble_cnt), .state_dbg(state_dbg)
  );

  // Narrow-counter copy fed the same stimulus, for saturation
  ctrl_pipe_unit #(.ALU_OP_W(3), .REG_W(5), .MUL_LAT(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op), .funct(funct),
    .rs(rs), .rt(rt), .rd(rd), .stall_ext(stall_ext), .flush(flush),
    .id_stall(id_stall2), .ex_valid(ex_valid2), .ex_ctrl(ex_ctrl2),
    .ex_rs(ex_rs2), .ex_rt(ex_rt2), .ex_wa(ex_wa2), .ex_busy(ex_busy2),
    .illegal(illegal2), .bubble_cnt(bubble_cnt2), .state_dbg(state_dbg2)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: registered outputs compared on the falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [REC_W-1:0] e;
      e = exp_q.pop_front();
      chk($sformatf("ex_outputs t=%0t", $time),
          64'({ex_valid, ex_ctrl, ex_wa, ex_rs, ex_rt, ex_busy, illegal, bubble_cnt, bubble_cnt2}),
          64'(e));
    end
  end

  task automatic drv(input logic v, input logic [5:0] o, input logic [5:0] f,
                     input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    in_valid = v; op = o; funct = f; rs = s; rt = t; rd = d;
    stall_ext = 1'b0; flush = 1'b0;
  endtask

  // One cycle from a falling edge: check id_stall, queue EX expectation
  task automatic cyc(input logic e_stall, input logic e_v, input logic [11:0] e_ctrl,
                     input logic [4:0] e_wa, input logic [4:0] e_rs, input logic [4:0] e_rt,
                     input logic e_busy, input logic e_ill);
    logic [1:0] bc2;
    #1;
    chk($sformatf("id_stall t=%0t", $time), 64'(id_stall), 64'(e_stall));
    bc2 = (bc_e > 3) ? 2'd3 : 2'(bc_e);
    exp_q.push_back({e_v, e_ctrl, e_wa, e_rs, e_rt, e_busy, e_ill, 16'(bc_e), bc2});
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0; n_pass = 0; bc_e = 0;
    rst_n = 1'b0;
    drv(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("reset_outputs", 64'({ex_valid, ex_ctrl, ex_wa, ex_rs, ex_rt, ex_busy, illegal, bubble_cnt}), 64'(0));
    chk("reset_id_stall", 64'(id_stall), 64'(0));
    rst_n = 1'b1;

    // All seven opcodes back to back
    drv(1, OP_ORI,   0,     1, 7, 3);  cyc(0, 1, C_ORI,  7, 1, 7, 0, 0);
    drv(1, OP_RTYPE, F_ADD, 2, 3, 4);  cyc(0, 1, C_R,    4, 2, 3, 0, 0);
    drv(1, OP_LW,    0,     1, 9, 0);  cyc(0, 1, C_LW,   9, 1, 9, 0, 0);
    drv(1, OP_SW,    0,     2, 10, 0); cyc(0, 1, C_SW,  10, 2, 10, 0, 0);
    drv(1, OP_BEQ,   0,     3, 4, 0);  cyc(0, 1, C_BEQ,  4, 3, 4, 0, 0);
    drv(1, OP_JAL,   0,     5, 6, 0);  cyc(0, 1, C_JAL,  6, 5, 6, 0, 0);
    drv(1, OP_XORI,  0,     8, 11, 0); cyc(0, 1, C_XORI, 11, 8, 11, 0, 0);

    // Load-use on rs: one bubble then the R-type
    drv(1, OP_LW, 0, 1, 5, 0);          cyc(0, 1, C_LW, 5, 1, 5, 0, 0);
    drv(1, OP_RTYPE, F_ADD, 5, 6, 12);  bc_e = 1; cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, C_R, 12, 5, 6, 0, 0);
    // Load-use on rt for a store
    drv(1, OP_LW, 0, 0, 6, 0);          cyc(0, 1, C_LW, 6, 0, 6, 0, 0);
    drv(1, OP_SW, 0, 1, 6, 0);          bc_e = 2; cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, C_SW, 6, 1, 6, 0, 0);
    // rt match on an instruction that does not read rt: no stall
    drv(1, OP_LW, 0, 0, 8, 0);          cyc(0, 1, C_LW, 8, 0, 8, 0, 0);
    drv(1, OP_ORI, 0, 2, 8, 0);         cyc(0, 1, C_ORI, 8, 2, 8, 0, 0);
    // Load to register 0: no stall
    drv(1, OP_LW, 0, 1, 0, 0);          cyc(0, 1, C_LW, 0, 1, 0, 0, 0);
    drv(1, OP_RTYPE, F_ADD, 0, 0, 3);   cyc(0, 1, C_R, 3, 0, 0, 0, 0);

    // Multiply: busy 4 cycles, 3 stall cycles
    drv(1, OP_RTYPE, FUNCT_MULT, 2, 3, 0); cyc(0, 1, C_R, 0, 2, 3, 1, 0);
    drv(1, OP_ORI, 0, 1, 13, 0);
    repeat (3) cyc(1, 1, C_R, 0, 2, 3, 1, 0);
    cyc(0, 1, C_ORI, 13, 1, 13, 0, 0);

    // Multiply with two external stall cycles: busy 6 cycles
    drv(1, OP_RTYPE, FUNCT_MULT, 4, 5, 0); cyc(0, 1, C_R, 0, 4, 5, 1, 0);
    drv(1, OP_ORI, 0, 1, 13, 0);        cyc(1, 1, C_R, 0, 4, 5, 1, 0);
    stall_ext = 1'b1;
    repeat (2) cyc(1, 1, C_R, 0, 4, 5, 1, 0);
    stall_ext = 1'b0;
    repeat (2) cyc(1, 1, C_R, 0, 4, 5, 1, 0);
    cyc(0, 1, C_ORI, 13, 1, 13, 0, 0);

    // Flush under stall_ext holds; flush alone bubbles without illegal
    drv(1, OP_BAD, 0, 0, 0, 0);
    stall_ext = 1'b1; flush = 1'b1;     cyc(1, 1, C_ORI, 13, 1, 13, 0, 0);
    stall_ext = 1'b0;                   cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // Illegal opcode
    drv(1, OP_BAD, 0, 3, 4, 5);         cyc(0, 0, 0, 0, 0, 0, 0, 1);
    drv(1, OP_ORI, 0, 1, 13, 0);        cyc(0, 1, C_ORI, 13, 1, 13, 0, 0);
    drv(1, OP_BAD, 0, 3, 4, 5);         cyc(0, 0, 0, 0, 0, 0, 0, 1);
    drv(0, OP_BAD, 0, 3, 4, 5);         cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // Three more hazards: narrow counter saturates at 3
    for (int k = 0; k < 3; k++) begin
      drv(1, OP_LW, 0, 1, 5, 0);        cyc(0, 1, C_LW, 5, 1, 5, 0, 0);
      drv(1, OP_RTYPE, F_ADD, 5, 6, 12); bc_e++; cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, C_R, 12, 5, 6, 0, 0);
    end

    // Reset during a multiply with cnt=2
    drv(1, OP_RTYPE, FUNCT_MULT, 2, 3, 0); cyc(0, 1, C_R, 0, 2, 3, 1, 0);
    drv(1, OP_ORI, 0, 1, 13, 0);        cyc(1, 1, C_R, 0, 2, 3, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midmul_reset_outputs", 64'({ex_valid, ex_ctrl, ex_wa, ex_rs, ex_rt, ex_busy, illegal, bubble_cnt}), 64'(0));
    chk("midmul_reset_id_stall", 64'(id_stall), 64'(0));
    chk("midmul_reset_state", 64'(state_dbg), 64'(IDLE));
    chk("midmul_reset_bc2", 64'(bubble_cnt2), 64'(0));
    @(negedge clk);
    rst_n = 1'b1; bc_e = 0;
    drv(1, OP_XORI, 0, 8, 11, 0);       cyc(0, 1, C_XORI, 11, 8, 11, 0, 0);
    drv(0, 0, 0, 0, 0, 0);

    @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
